big_core_fpga_in_debounce: RTL and testbench
============================================

BIG_CORE_FPGA_IN_DEBOUNCE -- requirements
Module: big_core_fpga_in_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 50000, meaning the number of consecutive stable synchronized cycles (1 ms at 50 MHz) required to accept a new input level; legal range 1..65535.
REQ-002 SHALL have port Clk, input, 1, the single clock; one clock, all logic in this domain.
REQ-003 SHALL have port Rst_N, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port Button_0_raw, input, 1, asynchronous board pushbutton 0.
REQ-005 SHALL have port Button_1_raw, input, 1, asynchronous board pushbutton 1.
REQ-006 SHALL have port Switch_raw, input, 10, asynchronous board slide switches.
REQ-007 SHALL have port Button_0, output, 1, debounced level; feeds the CR memory Button_0 input.
REQ-008 SHALL have port Button_1, output, 1, debounced level; feeds the CR memory Button_1 input.
REQ-009 SHALL have port Switch, output, 10, debounced levels; feeds the CR memory Switch input.
REQ-010 SHALL have port Button_0_press, output, 1, one-cycle pulse on the debounced 0->1 transition.
REQ-011 SHALL have port Button_1_press, output, 1, one-cycle pulse on the debounced 0->1 transition.
REQ-012 SHALL have port Switch_chg, output, 1, one-cycle pulse when any debounced Switch bit changes.

Function
REQ-013 SHALL pass each of the 12 raw bits through a 2-flop synchronizer before any other use.
REQ-014 SHALL give each channel an independent 16-bit counter and a registered stable level.
REQ-015 SHALL clear the channel counter in any cycle where the synchronized bit equals the stable level.
REQ-016 SHALL increment the counter while the synchronized bit differs from the stable level.
REQ-017 SHALL, in the cycle the counter equals DEBOUNCE_CNT-1 and the bit still differs, load the stable level with the synchronized bit and clear the counter.
REQ-018 SHALL, for a clean step on a raw input, update the output exactly 2+DEBOUNCE_CNT clock edges after the first sampling edge.
REQ-019 SHALL reject any glitch that differs for fewer than DEBOUNCE_CNT consecutive synchronized cycles; the counter restarts from 0 on each bounce.
REQ-020 SHALL never wrap or overflow the counter; maximum value is DEBOUNCE_CNT-1.
REQ-021 SHALL assert each press pulse in the same cycle the corresponding debounced output first reads 1; no pulse on 1->0.
REQ-022 SHALL assert Switch_chg for exactly one cycle when one or more Switch bits update in the same cycle; several bits updating together give one pulse.
REQ-023 SHALL drive all outputs directly from flops.

Reset
REQ-024 SHALL, while Rst_N=0, asynchronously force synchronizers, counters, stable levels and all outputs to 0.
REQ-025 SHALL, on a reset asserted mid-count, discard the partial count; after release, a held input needs the full 2+DEBOUNCE_CNT cycles.
REQ-026 SHALL produce no press or Switch_chg pulse on the first cycles after reset release unless a debounced 0->1 occurs.

Configuration
REQ-027 SHALL, with BIG_CORE_BUTTON_ACTIVE_LOW_EN defined, invert Button_0_raw and Button_1_raw before synchronization, so a pressed active-low key reads 1.
REQ-028 SHALL, without BIG_CORE_BUTTON_ACTIVE_LOW_EN, use button inputs unmodified; Switch_raw is never inverted in either mode.

Structure
REQ-029 SHALL take the default DEBOUNCE_CNT constant and the counter width (16) from common_pkg.
REQ-030 SHALL implement one channel (synchronizer, counter, stable level) as sub-module big_core_debounce_ch, instantiated 12 times.
REQ-031 SHALL generate the edge and change pulses in the top module.

Verification (bench with DEBOUNCE_CNT=4)
REQ-032 Reset with all raw inputs 1 -> all outputs 0 during reset; Button_0=1 at the 6th edge after release; Button_0_press high only that cycle.
REQ-033 Button_1_raw toggles 0/1 every 2 cycles for 20 cycles, then holds 0 -> Button_1 stays 0, no press pulse.
REQ-034 Switch_raw 0x000->0x3FF in one cycle -> Switch=0x3FF after 6 edges, Switch_chg high exactly one cycle.
REQ-035 Button_0 held 1 and stable, then Rst_N pulsed low for 1 cycle at counter value 2 of a new transition -> outputs 0 immediately; re-debounce takes the full 6 edges.
REQ-036 BIG_CORE_BUTTON_ACTIVE_LOW_EN defined, Button_0_raw driven 0 -> Button_0=1 after 6 edges; Switch_raw=0x001 -> Switch=0x001, not inverted.

Source files
------------

// File: rtl/common_pkg.sv
// Shared constants for the board-input conditioning blocks: default debounce
// interval, counter width and channel layout of the input bundle.
package common_pkg;

  localparam int DEBOUNCE_CNT_DEFAULT = 50000;
  localparam int DEBOUNCE_CNT_W       = 16;

  typedef logic [DEBOUNCE_CNT_W-1:0] debounce_cnt_t;

  // Channel map: bit 0/1 are the pushbuttons, bits 2..11 the slide switches.
  localparam int CH_B0     = 0;
  localparam int CH_B1     = 1;
  localparam int CH_SW_LSB = 2;
  localparam int SW_W      = 10;
  localparam int N_CH      = CH_SW_LSB + SW_W;

endpackage

// File: rtl/big_core_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, saturating stability counter and
// registered stable level. update is high in the cycle the level is reloaded.
module big_core_debounce_ch
  import common_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic update
);

  localparam debounce_cnt_t CNT_MAX = debounce_cnt_t'(DEBOUNCE_CNT - 1);

  logic          sync_1;
  logic          sync_2;
  debounce_cnt_t cnt;
  logic          differs;

  assign differs = (sync_2 != level);
  // The count never passes CNT_MAX: reaching it with the bit still different
  // commits the new level and restarts the counter.
  assign update  = differs && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (!differs) begin
        cnt <= '0;
      end else if (update) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/big_core_fpga_in_debounce.sv
// Debounces the two board pushbuttons and ten slide switches and generates
// press / switch-change pulses. Define BIG_CORE_BUTTON_ACTIVE_LOW_EN for active-low keys.
module big_core_fpga_in_debounce
  import common_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst_N,
  input  logic            Button_0_raw,
  input  logic            Button_1_raw,
  input  logic [SW_W-1:0] Switch_raw,
  output logic            Button_0,
  output logic            Button_1,
  output logic [SW_W-1:0] Switch,
  output logic            Button_0_press,
  output logic            Button_1_press,
  output logic            Switch_chg
);

  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] update;

`ifdef BIG_CORE_BUTTON_ACTIVE_LOW_EN
  assign raw_in = {Switch_raw, ~Button_1_raw, ~Button_0_raw};
`else
  assign raw_in = {Switch_raw, Button_1_raw, Button_0_raw};
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    big_core_debounce_ch #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_ch (
      .clk   (Clk),
      .rst_n (Rst_N),
      .raw   (raw_in[i]),
      .level (level[i]),
      .update(update[i])
    );
  end

  assign Button_0 = level[CH_B0];
  assign Button_1 = level[CH_B1];
  assign Switch   = level[CH_SW_LSB +: SW_W];

  // A reload always flips the level, so a reload from 0 is a rising edge;
  // registering it lines the pulse up with the first cycle the level reads 1.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      Button_0_press <= 1'b0;
      Button_1_press <= 1'b0;
      Switch_chg     <= 1'b0;
    end else begin
      Button_0_press <= update[CH_B0] & ~level[CH_B0];
      Button_1_press <= update[CH_B1] & ~level[CH_B1];
      Switch_chg     <= |update[CH_SW_LSB +: SW_W];
    end
  end

endmodule

// File: tb/tb_big_core_fpga_in_debounce.sv
// Self-checking bench for big_core_fpga_in_debounce with DEBOUNCE_CNT=4:
// directed + random stimulus, expected outputs queued per cycle and compared on negedge.
module tb_big_core_fpga_in_debounce;

  localparam int N   = 4;
  localparam int LAT = N + 2;
  localparam int W   = 15;

`ifdef BIG_CORE_BUTTON_ACTIVE_LOW_EN
  localparam logic BTN_INV = 1'b1;
`else
  localparam logic BTN_INV = 1'b0;
`endif

  typedef struct packed {
    logic       b0;
    logic       b1;
    logic [9:0] sw;
    logic       b0p;
    logic       b1p;
    logic       swc;
  } exp_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       b0_raw = 1'b0;
  logic       b1_raw = 1'b0;
  logic [9:0] sw_raw = '0;
  logic       button_0, button_1, button_0_press, button_1_press, switch_chg;
  logic [9:0] switch_q;

  big_core_fpga_in_debounce #(.DEBOUNCE_CNT(N)) dut (
    .Clk           (clk),
    .Rst_N         (rst_n),
    .Button_0_raw  (b0_raw),
    .Button_1_raw  (b1_raw),
    .Switch_raw    (sw_raw),
    .Button_0      (button_0),
    .Button_1      (button_1),
    .Switch        (switch_q),
    .Button_0_press(button_0_press),
    .Button_1_press(button_1_press),
    .Switch_chg    (switch_chg)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         mon_e;

  logic       cur_b0 = 1'b0;
  logic       cur_b1 = 1'b0;
  logic [9:0] cur_sw = '0;
  logic [9:0] saved_sw;
  logic [9:0] rnd_sw;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " b0"},  16'(button_0),       16'(e.b0));
    check({tag, " b1"},  16'(button_1),       16'(e.b1));
    check({tag, " sw"},  16'(switch_q),       16'(e.sw));
    check({tag, " b0p"}, 16'(button_0_press), 16'(e.b0p));
    check({tag, " b1p"}, 16'(button_1_press), 16'(e.b1p));
    check({tag, " swc"}, 16'(switch_chg),     16'(e.swc));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_outputs("cyc", mon_e);
    end
  end

  function automatic exp_t mk(input logic b0, input logic b1, input logic [9:0] sw,
                              input logic b0p, input logic b1p, input logic swc);
    exp_t e;
    e.b0  = b0;
    e.b1  = b1;
    e.sw  = sw;
    e.b0p = b0p;
    e.b1p = b1p;
    e.swc = swc;
    return e;
  endfunction

  // driver: b0/b1 are logical "pressed" levels; the active-low build inverts them on the pins
  task automatic drive_cycle(input logic b0, input logic b1, input logic [9:0] sw, input exp_t e);
    b0_raw = b0 ^ BTN_INV;
    b1_raw = b1 ^ BTN_INV;
    sw_raw = sw;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  // Clean step from a settled state: each changed output moves on edge LAT after the first sample.
  task automatic hold(input logic b0, input logic b1, input logic [9:0] sw, input int cycles);
    exp_t e;
    for (int k = 1; k <= cycles; k++) begin
      e.b0  = (k >= LAT) ? b0 : cur_b0;
      e.b1  = (k >= LAT) ? b1 : cur_b1;
      e.sw  = (k >= LAT) ? sw : cur_sw;
      e.b0p = (k == LAT) && b0 && !cur_b0;
      e.b1p = (k == LAT) && b1 && !cur_b1;
      e.swc = (k == LAT) && (sw != cur_sw);
      drive_cycle(b0, b1, sw, e);
    end
    if (cycles >= LAT) begin
      cur_b0 = b0;
      cur_b1 = b1;
      cur_sw = sw;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = mk(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);

    // Reset with all inputs active: outputs held at 0
    b0_raw = 1'b1 ^ BTN_INV;
    b1_raw = 1'b1 ^ BTN_INV;
    sw_raw = 10'h3FF;
    #1;
    check_outputs("rst", z);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 10'h3FF, z);
    rst_n = 1'b1;
    hold(1'b1, 1'b1, 10'h3FF, 8);

    // Button_1 release (no pulse on 1->0), then bounce every 2 cycles, then held low
    hold(1'b1, 1'b0, 10'h3FF, 8);
    for (int i = 0; i < 20; i++)
      drive_cycle(1'b1, ((i / 2) % 2) == 0, 10'h3FF,
                  mk(cur_b0, cur_b1, cur_sw, 1'b0, 1'b0, 1'b0));
    hold(1'b1, 1'b0, 10'h3FF, 8);

    // Switch all-ones -> zero -> all-ones, then random words
    hold(1'b1, 1'b0, 10'h000, 8);
    hold(1'b1, 1'b0, 10'h3FF, 8);
    for (int i = 0; i < 4; i++) begin
      rnd_sw = 10'($urandom_range(0, 1023));
      hold(1'b1, 1'b0, rnd_sw, 8);
    end

    // Switch glitch of N-1 cycles is rejected
    for (int i = 0; i < N - 1; i++)
      drive_cycle(cur_b0, cur_b1, cur_sw ^ 10'h001,
                  mk(cur_b0, cur_b1, cur_sw, 1'b0, 1'b0, 1'b0));
    hold(cur_b0, cur_b1, cur_sw, 6);

    // Button_0 low glitch of N-1 cycles is rejected
    for (int i = 0; i < N - 1; i++)
      drive_cycle(1'b0, cur_b1, cur_sw, mk(1'b1, cur_b1, cur_sw, 1'b0, 1'b0, 1'b0));
    hold(1'b1, cur_b1, cur_sw, 6);

    // Button_0 low pulse of exactly N cycles is accepted, and so is the return to 1
    for (int k = 1; k <= 12; k++)
      drive_cycle((k > N), cur_b1, cur_sw,
                  mk(!(k >= LAT && k <= LAT + N - 1), cur_b1, cur_sw,
                     (k == LAT + N), 1'b0, 1'b0));

    // Reset mid-count (counter at 2) discards the partial count
    for (int k = 1; k <= 4; k++)
      drive_cycle(1'b0, cur_b1, cur_sw, mk(1'b1, cur_b1, cur_sw, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    rst_n  = 1'b0;
    b0_raw = 1'b1 ^ BTN_INV;
    #1;
    check_outputs("rst_mid", z);
    drive_cycle(1'b1, cur_b1, cur_sw, z);
    rst_n    = 1'b1;
    saved_sw = cur_sw;
    cur_b0   = 1'b0;
    cur_b1   = 1'b0;
    cur_sw   = '0;
    hold(1'b1, 1'b0, saved_sw, 8);

    // Button polarity handling and non-inverted switches
    hold(1'b0, 1'b0, 10'h001, 8);
    hold(1'b1, 1'b0, 10'h001, 8);

    @(negedge clk);
    #1;
    check("q_drain", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
